pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register placed between two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque packed stage bundle of any width under a valid/allowin handshake, with flush support and an optional two-entry skid mode. The skid mode breaks the combinational `allowin` path between stages. A saturating stall counter is included for performance analysis. It replaces fixed-width, handshake-free stage registers.

---
 rtl/pipe_stage_reg.sv | 107 ++++++++++
 tb/tb_pipe_stage_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/allowin pipeline register between two CPU stages, with
// flush, an optional two-entry skid buffer and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 218,
  parameter int SKID   = 0,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_allowin,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_allowin,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_valid_nx, skid_valid_nx;
  logic [DATA_W-1:0] main_data_nx, skid_data_nx;
  logic              accept, deliver;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign accept  = in_valid & in_allowin;
  assign deliver = main_valid & out_allowin;

  always_comb begin
    main_valid_nx = main_valid;
    main_data_nx  = main_data;
    skid_valid_nx = skid_valid;
    skid_data_nx  = skid_data;
    if (SKID == 0) begin
      if (accept) begin
        main_valid_nx = 1'b1;
        main_data_nx  = in_data;
      end else if (deliver) begin
        main_valid_nx = 1'b0;
      end
    end else begin
      // A full skid entry implies in_allowin=0, so no accept competes with the refill.
      if (skid_valid) begin
        if (deliver) begin
          main_data_nx  = skid_data;
          skid_valid_nx = 1'b0;
        end
      end else if (!main_valid || deliver) begin
        main_valid_nx = accept;
        if (accept) main_data_nx = in_data;
      end else if (accept) begin
        skid_valid_nx = 1'b1;
        skid_data_nx  = in_data;
      end
    end
    // Flush only kills valid bits; data flops keep whatever they loaded.
    if (flush) begin
      main_valid_nx = 1'b0;
      skid_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      main_valid <= main_valid_nx;
      skid_valid <= skid_valid_nx;
      main_data  <= main_data_nx;
      skid_data  <= skid_data_nx;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic allow_q;
      // Registered so out_allowin never reaches in_allowin combinationally.
      always_ff @(posedge clk) begin
        if (!resetn) allow_q <= 1'b1;
        else         allow_q <= !skid_valid_nx;
      end
      assign in_allowin = allow_q;
    end else begin : g_noskid
      assign in_allowin = !main_valid | out_allowin;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn)                       stall_cnt <= '0;
    else if (cnt_clr)                  stall_cnt <= '0;
    else if (main_valid && !out_allowin) stall_cnt <= sat_inc(stall_cnt);
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance, checked against
// a queue-based reference model plus hand-derived vector tables.
module tb_pipe_stage_reg;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          iv [2];
  logic [DW-1:0] id [2];
  logic          oa [2];
  logic          fl [2];
  logic          clr [2];
  logic          ia [2];
  logic          ov [2];
  logic [DW-1:0] od [2];
  logic [3:0]    cnt0;
  logic [7:0]    cnt1;

  pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CNT_W(4)) u_d0 (
    .clk(clk), .resetn(resetn), .in_valid(iv[0]), .in_data(id[0]),
    .in_allowin(ia[0]), .out_valid(ov[0]), .out_data(od[0]),
    .out_allowin(oa[0]), .flush(fl[0]), .cnt_clr(clr[0]), .stall_cnt(cnt0)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CNT_W(8)) u_d1 (
    .clk(clk), .resetn(resetn), .in_valid(iv[1]), .in_data(id[1]),
    .in_allowin(ia[1]), .out_valid(ov[1]), .out_data(od[1]),
    .out_allowin(oa[1]), .flush(fl[1]), .cnt_clr(clr[1]), .stall_cnt(cnt1)
  );

  typedef struct {
    int          m;
    bit          v;
    logic [DW-1:0] d;
    bit          a;
    bit          f;
    bit          c;
    bit          e_ia;
    bit          e_ov;
    logic [DW-1:0] e_od;
    int          e_cnt;
  } vec_t;

  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  int mcnt [2];
  int errors = 0;
  int checks = 0;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [DW-1:0] qfront(input int m);
    return (m == 0) ? q0[0] : q1[0];
  endfunction

  function automatic bit m_allow(input int m, input bit a);
    return (m == 0) ? (q0.size() == 0 || a) : (q1.size() < 2);
  endfunction

  function automatic logic [63:0] cnt_of(input int m);
    return (m == 0) ? {60'd0, cnt0} : {56'd0, cnt1};
  endfunction

  function automatic vec_t mk(input int m, input bit v, input logic [DW-1:0] d,
                              input bit a, input bit f, input bit c);
    vec_t t;
    t = '{m, v, d, a, f, c, 1'b0, 1'b0, '0, 0};
    return t;
  endfunction

  task automatic set_idle();
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; id[k] = '0; oa[k] = 1'b1; fl[k] = 1'b0; clr[k] = 1'b0;
    end
  endtask

  task automatic check_model(input int m, input string tag);
    chk($sformatf("%s_m%0d_allowin", tag, m), ia[m], m_allow(m, oa[m]));
    chk($sformatf("%s_m%0d_valid", tag, m), ov[m], qsize(m) > 0);
    if (qsize(m) > 0) chk($sformatf("%s_m%0d_data", tag, m), od[m], qfront(m));
    chk($sformatf("%s_m%0d_cnt", tag, m), cnt_of(m), mcnt[m]);
  endtask

  task automatic model_edge(input int m);
    int n;
    bit al;
    bit del;
    n   = qsize(m);
    al  = m_allow(m, oa[m]);
    del = (n > 0) && oa[m];
    if (clr[m]) mcnt[m] = 0;
    else if (n > 0 && !oa[m] && mcnt[m] < ((m == 0) ? 15 : 255)) mcnt[m]++;
    if (m == 0) begin
      if (del) void'(q0.pop_front());
      if (iv[0] && al) q0.push_back(id[0]);
      if (fl[0]) q0.delete();
    end else begin
      if (del) void'(q1.pop_front());
      if (iv[1] && al) q1.push_back(id[1]);
      if (fl[1]) q1.delete();
    end
  endtask

  task automatic step(input vec_t t, input bit use_exp, input string tag);
    @(negedge clk);
    set_idle();
    iv[t.m] = t.v; id[t.m] = t.d; oa[t.m] = t.a; fl[t.m] = t.f; clr[t.m] = t.c;
    #1;
    check_model(0, tag);
    check_model(1, tag);
    if (use_exp) begin
      chk({tag, "_allowin"}, ia[t.m], t.e_ia);
      chk({tag, "_valid"}, ov[t.m], t.e_ov);
      if (t.e_ov) chk({tag, "_data"}, od[t.m], t.e_od);
      chk({tag, "_cnt"}, cnt_of(t.m), t.e_cnt);
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
  endtask

  task automatic apply_reset(input int n, input string tag);
    @(negedge clk);
    resetn = 1'b0;
    set_idle();
    repeat (n) @(posedge clk);
    q0.delete();
    q1.delete();
    mcnt[0] = 0;
    mcnt[1] = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_m%0d_valid", tag, k), ov[k], 1'b0);
      chk($sformatf("%s_m%0d_data", tag, k), od[k], '0);
      chk($sformatf("%s_m%0d_allowin", tag, k), ia[k], 1'b1);
      chk($sformatf("%s_m%0d_cnt", tag, k), cnt_of(k), 0);
    end
    resetn = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    // m, v, d, a, f, c, e_ia, e_ov, e_od, e_cnt
    tbl.push_back('{0, 1, 'h1, 1, 0, 0, 1, 0, 'h0, 0});
    tbl.push_back('{0, 1, 'h2, 1, 0, 0, 1, 1, 'h1, 0});
    tbl.push_back('{0, 1, 'h3, 1, 0, 0, 1, 1, 'h2, 0});
    tbl.push_back('{0, 0, 'h0, 1, 0, 0, 1, 1, 'h3, 0});
    tbl.push_back('{0, 1, 'hA, 1, 0, 0, 1, 0, 'h0, 0});
    tbl.push_back('{0, 1, 'hB, 0, 0, 0, 0, 1, 'hA, 0});
    tbl.push_back('{0, 1, 'hB, 0, 0, 0, 0, 1, 'hA, 1});
    tbl.push_back('{0, 1, 'hB, 0, 0, 0, 0, 1, 'hA, 2});
    tbl.push_back('{0, 1, 'hB, 1, 0, 0, 1, 1, 'hA, 3});
    tbl.push_back('{0, 0, 'h0, 1, 0, 0, 1, 1, 'hB, 3});
    tbl.push_back('{0, 1, 'hD, 1, 0, 0, 1, 0, 'h0, 3});
    tbl.push_back('{0, 1, 'h9, 0, 1, 0, 0, 1, 'hD, 3});
    tbl.push_back('{0, 0, 'h0, 0, 0, 0, 1, 0, 'h0, 4});
    tbl.push_back('{0, 1, 'hE, 1, 0, 0, 1, 0, 'h0, 4});
    tbl.push_back('{0, 1, 'hF, 1, 1, 0, 1, 1, 'hE, 4});
    tbl.push_back('{0, 0, 'h0, 1, 0, 0, 1, 0, 'h0, 4});
    tbl.push_back('{1, 1, 'h1, 1, 0, 0, 1, 0, 'h0, 0});
    tbl.push_back('{1, 1, 'h2, 1, 0, 0, 1, 1, 'h1, 0});
    tbl.push_back('{1, 1, 'h3, 1, 0, 0, 1, 1, 'h2, 0});
    tbl.push_back('{1, 0, 'h0, 1, 0, 0, 1, 1, 'h3, 0});
    tbl.push_back('{1, 1, 'h1, 0, 0, 0, 1, 0, 'h0, 0});
    tbl.push_back('{1, 1, 'h2, 0, 0, 0, 1, 1, 'h1, 0});
    tbl.push_back('{1, 1, 'h3, 0, 0, 0, 0, 1, 'h1, 1});
    tbl.push_back('{1, 1, 'h3, 1, 0, 0, 0, 1, 'h1, 2});
    tbl.push_back('{1, 1, 'h3, 1, 0, 0, 1, 1, 'h2, 2});
    tbl.push_back('{1, 0, 'h0, 1, 0, 0, 1, 1, 'h3, 2});
    tbl.push_back('{1, 1, 'h4, 0, 0, 0, 1, 0, 'h0, 2});
    tbl.push_back('{1, 1, 'h5, 0, 0, 0, 1, 1, 'h4, 2});
    tbl.push_back('{1, 1, 'h9, 0, 1, 0, 0, 1, 'h4, 3});
    tbl.push_back('{1, 0, 'h0, 1, 0, 0, 1, 0, 'h0, 4});
    tbl.push_back('{1, 0, 'h0, 1, 0, 0, 1, 0, 'h0, 4});
    tbl.push_back('{1, 1, 'h6, 0, 0, 0, 1, 0, 'h0, 4});
    tbl.push_back('{1, 1, 'h9, 0, 1, 0, 1, 1, 'h6, 4});
    tbl.push_back('{1, 0, 'h0, 1, 0, 0, 1, 0, 'h0, 5});

    apply_reset(2, "reset");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], 1'b1, $sformatf("row%0d", i));

    // Saturation on the 4-bit counter, then clear during a stalled cycle.
    step(mk(0, 1, 'hC, 1, 0, 0), 1'b0, "sat_load");
    for (int i = 0; i < 20; i++) step(mk(0, 0, '0, 0, 0, 0), 1'b0, "sat_stall");
    step('{0, 0, 'h0, 0, 0, 1, 0, 1, 'hC, 15}, 1'b1, "sat_clr");
    step('{0, 0, 'h0, 1, 0, 0, 1, 1, 'hC, 0}, 1'b1, "sat_after");

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 150; i++)
        step(mk(m, $urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0), 1'b0, "rand");
      for (int i = 0; i < 3; i++) step(mk(m, 0, '0, 1, 0, 0), 1'b0, "drain");
    end

    step(mk(1, 1, 'h7, 0, 0, 0), 1'b0, "mid_fill");
    step(mk(1, 1, 'h8, 0, 0, 0), 1'b0, "mid_fill");
    step('{1, 0, 'h0, 0, 0, 0, 0, 1, 'h7, mcnt[1]}, 1'b1, "mid_full");
    apply_reset(1, "mid_reset");
    step('{1, 0, 'h0, 1, 0, 0, 1, 0, 'h0, 0}, 1'b1, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
